// File: rtl/sr_ff_bank.sv
// Bank of independent clocked SR flip-flops with a configurable S=R=1 response,
// sticky per-channel conflict flags and a saturating conflict-cycle counter.
module sr_ff_bank #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned INV_MODE = 0,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_n,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] both;

  assign both = S & R;

  always_comb begin
    q_d = q_q;
    if (en) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        case ({S[i], R[i]})
          2'b10:   q_d[i] = 1'b1;
          2'b01:   q_d[i] = 1'b0;
          2'b11: begin
            case (INV_MODE)
              1:       q_d[i] = 1'b1;
              2:       q_d[i] = 1'b0;
              3:       q_d[i] = ~q_q[i];
              default: q_d[i] = q_q[i];
            endcase
          end
          default: q_d[i] = q_q[i];
        endcase
      end
    end
  end

  // Clear is applied before a same-cycle conflict is recorded.
  always_comb begin
    flag_d = clr_flags ? '0 : flag_q;
    cnt_d  = clr_flags ? '0 : cnt_q;
    if (en && (|both)) begin
      flag_d = flag_d | both;
      if (cnt_d != CntMax) begin
        cnt_d = cnt_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= '0;
      flag_q <= '0;
      cnt_q  <= '0;
    end else begin
      q_q    <= q_d;
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign Q            = q_q;
  assign Q_n          = ~q_q;
  assign conflict     = flag_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Drives five sr_ff_bank instances (INV_MODE 0..3 with CNT_W=8, plus INV_MODE 0 with CNT_W=2)
// from shared stimulus and compares each against a per-channel behavioural model.
module tb_sr_ff_bank;

  localparam int NI = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] S;
  logic [3:0] R;
  logic       clr_flags;

  logic [3:0] q_a   [NI];
  logic [3:0] qn_a  [NI];
  logic [3:0] cf_a  [NI];
  logic [7:0] cnt_a [NI];
  logic [1:0] cnt_small;

  int n_vec = 0;
  int n_err = 0;

  // Model state per instance
  int mq [NI];
  int mf [NI];
  int mc [NI];

  always #5 clk = ~clk;

  sr_ff_bank #(.WIDTH(4), .INV_MODE(0), .CNT_W(8)) u_m0 (
    .clk(clk), .reset(reset), .en(en), .S(S), .R(R), .clr_flags(clr_flags),
    .Q(q_a[0]), .Q_n(qn_a[0]), .conflict(cf_a[0]), .conflict_cnt(cnt_a[0]));
  sr_ff_bank #(.WIDTH(4), .INV_MODE(1), .CNT_W(8)) u_m1 (
    .clk(clk), .reset(reset), .en(en), .S(S), .R(R), .clr_flags(clr_flags),
    .Q(q_a[1]), .Q_n(qn_a[1]), .conflict(cf_a[1]), .conflict_cnt(cnt_a[1]));
  sr_ff_bank #(.WIDTH(4), .INV_MODE(2), .CNT_W(8)) u_m2 (
    .clk(clk), .reset(reset), .en(en), .S(S), .R(R), .clr_flags(clr_flags),
    .Q(q_a[2]), .Q_n(qn_a[2]), .conflict(cf_a[2]), .conflict_cnt(cnt_a[2]));
  sr_ff_bank #(.WIDTH(4), .INV_MODE(3), .CNT_W(8)) u_m3 (
    .clk(clk), .reset(reset), .en(en), .S(S), .R(R), .clr_flags(clr_flags),
    .Q(q_a[3]), .Q_n(qn_a[3]), .conflict(cf_a[3]), .conflict_cnt(cnt_a[3]));
  sr_ff_bank #(.WIDTH(4), .INV_MODE(0), .CNT_W(2)) u_small (
    .clk(clk), .reset(reset), .en(en), .S(S), .R(R), .clr_flags(clr_flags),
    .Q(q_a[4]), .Q_n(qn_a[4]), .conflict(cf_a[4]), .conflict_cnt(cnt_small));

  assign cnt_a[4] = {6'b0, cnt_small};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int mode_of(input int k);
    return (k < 4) ? k : 0;
  endfunction

  function automatic int cmax_of(input int k);
    return (k < 4) ? 255 : 3;
  endfunction

  // Applies one rising edge worth of behaviour to every model instance.
  task automatic model_edge();
    for (int k = 0; k < NI; k++) begin
      if (reset) begin
        mq[k] = 0; mf[k] = 0; mc[k] = 0;
      end else begin
        if (clr_flags) begin
          mf[k] = 0; mc[k] = 0;
        end
        if (en) begin
          int any;
          any = 0;
          for (int i = 0; i < 4; i++) begin
            int bitv;
            bitv = (mq[k] >> i) & 1;
            if (S[i] && !R[i]) bitv = 1;
            else if (!S[i] && R[i]) bitv = 0;
            else if (S[i] && R[i]) begin
              any = 1;
              mf[k] = mf[k] | (1 << i);
              if (mode_of(k) == 1) bitv = 1;
              else if (mode_of(k) == 2) bitv = 0;
              else if (mode_of(k) == 3) bitv = 1 - bitv;
            end
            mq[k] = (mq[k] & ~(1 << i)) | (bitv << i);
          end
          if (any != 0 && mc[k] < cmax_of(k)) mc[k] = mc[k] + 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("q[%0d]", k), 32'(q_a[k]), 32'(mq[k]));
      check($sformatf("qn[%0d]", k), 32'(qn_a[k]), 32'((~mq[k]) & 15));
      check($sformatf("conflict[%0d]", k), 32'(cf_a[k]), 32'(mf[k]));
      check($sformatf("cnt[%0d]", k), 32'(cnt_a[k]), 32'(mc[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic rst, input logic e, input logic [3:0] s, input logic [3:0] r,
                       input logic c);
    reset = rst; en = e; S = s; R = r; clr_flags = c;
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      mq[k] = 0; mf[k] = 0; mc[k] = 0;
    end
    drive(1'b1, 1'b1, 4'b1111, 4'b0000, 1'b1);
    step();
    check("reset_q", 32'(q_a[0]), 32'h0);
    check("reset_qn", 32'(qn_a[0]), 32'hF);

    // Basic set / reset
    drive(1'b0, 1'b1, 4'b0101, 4'b0000, 1'b0);
    step();
    check("set_q", 32'(q_a[0]), 32'h5);
    check("set_qn", 32'(qn_a[0]), 32'hA);
    drive(1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0);
    step();
    check("rst_ch0_q", 32'(q_a[0]), 32'h4);

    // Disabled cycles hold and record nothing
    drive(1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0);
    repeat (3) step();
    drive(1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0);
    step();
    check("dis_q", 32'(q_a[0]), 32'h4);
    check("dis_conflict", 32'(cf_a[0]), 32'h0);
    check("dis_cnt", 32'(cnt_a[0]), 32'h0);

    // S=R=1 from Q=0100 in each mode
    drive(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0);
    step();
    check("inv0_q", 32'(q_a[0]), 32'h4);
    check("inv1_q", 32'(q_a[1]), 32'hF);
    check("inv2_q", 32'(q_a[2]), 32'h0);
    check("inv3_q", 32'(q_a[3]), 32'hB);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("inv%0d_conflict", k), 32'(cf_a[k]), 32'hF);
      check($sformatf("inv%0d_cnt", k), 32'(cnt_a[k]), 32'h1);
    end

    // Saturation of the narrow counter, then clear with a same-cycle conflict
    drive(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
    step();
    drive(1'b0, 1'b1, 4'b0001, 4'b0001, 1'b0);
    repeat (5) step();
    check("sat_cnt", 32'(cnt_small), 32'h3);
    check("wide_cnt5", 32'(cnt_a[0]), 32'h5);
    drive(1'b0, 1'b1, 4'b0010, 4'b0010, 1'b1);
    step();
    check("clr_conflict", 32'(cf_a[4]), 32'h2);
    check("clr_cnt", 32'(cnt_small), 32'h1);

    // Reset priority over a pending request
    drive(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
    step();
    drive(1'b0, 1'b1, 4'b0011, 4'b0011, 1'b0);
    repeat (5) step();
    drive(1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0);
    step();
    check("pre_q", 32'(q_a[0]), 32'hF);
    check("pre_conflict", 32'(cf_a[0]), 32'h3);
    check("pre_cnt", 32'(cnt_a[0]), 32'h5);
    drive(1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0);
    step();
    check("rprio_q", 32'(q_a[0]), 32'h0);
    check("rprio_qn", 32'(qn_a[0]), 32'hF);
    check("rprio_conflict", 32'(cf_a[0]), 32'h0);
    check("rprio_cnt", 32'(cnt_a[0]), 32'h0);
    drive(1'b0, 1'b1, 4'b0000, 4'b0010, 1'b0);
    step();
    check("post_rst_q", 32'(q_a[0]), 32'h0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
            4'($urandom), 4'($urandom), ($urandom_range(0, 15) == 0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
